// File: rtl/divider_unit.sv
// Sequential unsigned restoring divider (DIVU), one quotient bit per clock.
// dataOut = {remainder, quotient}; shares the multiplier's 6-bit opcode bus.
module divider_unit #(
    parameter int         WIDTH = 32,
    parameter logic [5:0] DIVU  = 6'b011011,
    parameter logic [5:0] OUT   = 6'b111111
) (
    input  logic               clk,
    input  logic               reset,
    input  logic [WIDTH-1:0]   dataA,
    input  logic [WIDTH-1:0]   dataB,
    input  logic [5:0]         Signal,
    output logic [2*WIDTH-1:0] dataOut,
    output logic               busy,
    output logic               done,
    output logic               div_by_zero
);

    localparam int   CW        = $clog2(WIDTH + 1);
    localparam logic ACCEPT_OK = (DIVU != OUT);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUSY = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t             state_q, state_d;
    logic [CW-1:0]      cnt_q, cnt_d;
    logic [WIDTH-1:0]   r_q, r_d;
    logic [WIDTH-1:0]   q_q, q_d;
    logic [WIDTH-1:0]   d_q, d_d;
    logic               zero_q, zero_d;
    logic               dbz_q, dbz_d;
    logic [2*WIDTH-1:0] out_q, out_d;

    logic               accept;
    logic [WIDTH:0]     t;
    logic [WIDTH-1:0]   r_sub;
    logic               ge;

    assign accept = (Signal == DIVU) && ACCEPT_OK;
    assign t      = {r_q, q_q[WIDTH-1]};
    assign ge     = t >= {1'b0, d_q};
    // Only used when ge holds, so the result always fits in WIDTH bits.
    assign r_sub  = t[WIDTH-1:0] - d_q;

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            r_q     <= '0;
            q_q     <= '0;
            d_q     <= '0;
            zero_q  <= 1'b0;
            dbz_q   <= 1'b0;
            out_q   <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            r_q     <= r_d;
            q_q     <= q_d;
            d_q     <= d_d;
            zero_q  <= zero_d;
            dbz_q   <= dbz_d;
            out_q   <= out_d;
        end
    end

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            IDLE, DONE: state_d = accept ? BUSY : IDLE;
            BUSY:       if (cnt_q == CW'(1)) state_d = DONE;
            default:    state_d = IDLE;
        endcase
    end

    // A zero divisor spends a single cycle in BUSY and then reports the
    // saturated quotient, giving it a one-cycle latency without iterating.
    always_comb begin
        cnt_d  = cnt_q;
        r_d    = r_q;
        q_d    = q_q;
        d_d    = d_q;
        zero_d = zero_q;
        dbz_d  = dbz_q;
        out_d  = out_q;
        if (state_q != BUSY && accept) begin
            d_d    = dataB;
            q_d    = dataA;
            r_d    = '0;
            zero_d = (dataB == '0);
            cnt_d  = (dataB == '0) ? CW'(1) : CW'(WIDTH);
            dbz_d  = 1'b0;
        end else if (state_q == BUSY) begin
            cnt_d = cnt_q - CW'(1);
            if (zero_q) begin
                if (cnt_q == CW'(1)) begin
                    out_d = {q_q, {WIDTH{1'b1}}};
                    dbz_d = 1'b1;
                end
            end else begin
                r_d = ge ? r_sub : t[WIDTH-1:0];
                q_d = {q_q[WIDTH-2:0], ge};
                if (cnt_q == CW'(1)) out_d = {r_d, q_d};
            end
        end
    end

    assign busy        = (state_q == BUSY);
    assign done        = (state_q == DONE);
    assign dataOut     = out_q;
    assign div_by_zero = dbz_q;

endmodule

// File: tb/tb_divider_unit.sv
// Self-checking bench for divider_unit: table vectors, hand sequences
// and a random sweep, with results matched through a scoreboard queue.
module tb_divider_unit;

    localparam int         W    = 32;
    localparam logic [5:0] DIVU = 6'b011011;
    localparam logic [5:0] OPO  = 6'b111111;

    logic           clk = 1'b0;
    logic           reset;
    logic [W-1:0]   dataA, dataB;
    logic [5:0]     Signal;
    logic [2*W-1:0] dataOut;
    logic           busy, done, div_by_zero;

    divider_unit #(.WIDTH(W), .DIVU(DIVU), .OUT(OPO)) dut (
        .clk         (clk),
        .reset       (reset),
        .dataA       (dataA),
        .dataB       (dataB),
        .Signal      (Signal),
        .dataOut     (dataOut),
        .busy        (busy),
        .done        (done),
        .div_by_zero (div_by_zero)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [2*W-1:0] o;
        logic           z;
    } exp_t;

    typedef struct {
        logic [W-1:0]   a;
        logic [W-1:0]   b;
        logic [2*W-1:0] o;
        logic           z;
    } vec_t;

    exp_t sb[$];
    int   checks   = 0;
    int   failures = 0;
    int   done_cnt = 0;

    task automatic chk(input string n, input logic [2*W-1:0] act,
                       input logic [2*W-1:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s got=%h exp=%h", n, act, exp);
        end
    endtask

    always @(negedge clk) begin
        if (done) begin
            exp_t e;
            done_cnt++;
            if (sb.size() == 0) begin
                checks++;
                failures++;
                $display("FAIL spurious_done got=1 exp=0");
            end else begin
                e = sb.pop_front();
                chk("dataOut", dataOut, e.o);
                chk("div_by_zero", {63'd0, div_by_zero}, {63'd0, e.z});
            end
        end
    end

    function automatic exp_t model(input logic [W-1:0] a, input logic [W-1:0] b);
        exp_t e;
        if (b == 0) begin
            e.o = {a, {W{1'b1}}};
            e.z = 1'b1;
        end else begin
            e.o = {a % b, a / b};
            e.z = 1'b0;
        end
        return e;
    endfunction

    // Entered just after an accept edge; returns at the negedge where done is seen.
    task automatic wait_done(input int max, input logic [2*W-1:0] prev,
                             output int lat, output int nb, output bit ok);
        lat = 0;
        nb  = 0;
        ok  = 1'b0;
        while (lat < max) begin
            @(negedge clk);
            lat++;
            if (lat == 1) begin
                chk("hold_prev", dataOut, prev);
                chk("dbz_clear", {63'd0, div_by_zero}, 64'd0);
            end
            if (busy) nb++;
            if (done) begin
                ok = 1'b1;
                break;
            end
        end
        if (!ok) begin
            checks++;
            failures++;
            $display("FAIL timeout got=no_done exp=done");
        end
    endtask

    task automatic do_div(input logic [W-1:0] a, input logic [W-1:0] b,
                          input exp_t e);
        int lat, nb;
        bit ok;
        logic [2*W-1:0] prev;
        prev   = dataOut;
        Signal = DIVU;
        dataA  = a;
        dataB  = b;
        sb.push_back(e);
        @(posedge clk);
        #1;
        Signal = OPO;
        dataA  = $urandom;
        dataB  = $urandom;
        wait_done(40, prev, lat, nb, ok);
        if (ok) begin
            chk("latency", 64'(lat), (b == 0) ? 64'd2 : 64'(W + 1));
            if (b != 0) chk("busy_cycles", 64'(nb), 64'(W));
        end
    endtask

    initial begin
        vec_t vt[9];
        exp_t e;
        int lat, nb, dc;
        bit ok;
        logic [W-1:0] a, b, qq, rr;

        vt[0] = '{32'd100,        32'd7,        {32'd2, 32'd14},              1'b0};
        vt[1] = '{32'hFFFFFFFF,   32'd1,        {32'd0, 32'hFFFFFFFF},        1'b0};
        vt[2] = '{32'd5,          32'd0,        {32'd5, 32'hFFFFFFFF},        1'b1};
        vt[3] = '{32'd0,          32'd5,        {32'd0, 32'd0},               1'b0};
        vt[4] = '{32'd7,          32'd7,        {32'd0, 32'd1},               1'b0};
        vt[5] = '{32'd6,          32'd7,        {32'd6, 32'd0},               1'b0};
        vt[6] = '{32'hFFFFFFFF,   32'hFFFFFFFF, {32'd0, 32'd1},               1'b0};
        vt[7] = '{32'h80000000,   32'd2,        {32'd0, 32'h40000000},        1'b0};
        vt[8] = '{32'hFFFFFFFF,   32'h00010000, {32'h0000FFFF, 32'h0000FFFF}, 1'b0};

        reset  = 1'b1;
        Signal = OPO;
        dataA  = '0;
        dataB  = '0;
        repeat (3) @(negedge clk);
        chk("rst_dataOut", dataOut, 64'd0);
        chk("rst_flags", {61'd0, busy, done, div_by_zero}, 64'd0);
        reset = 1'b0;
        @(negedge clk);

        for (int i = 0; i < 9; i++) begin
            e.o = vt[i].o;
            e.z = vt[i].z;
            do_div(vt[i].a, vt[i].b, e);
        end

        // div_by_zero persists through idle cycles after a zero divide
        do_div(32'd5, 32'd0, '{{32'd5, 32'hFFFFFFFF}, 1'b1});
        repeat (3) @(negedge clk);
        chk("dbz_held", {63'd0, div_by_zero}, 64'd1);

        // DIVU during BUSY is ignored
        Signal = DIVU;
        dataA  = 32'd3;
        dataB  = 32'd10;
        sb.push_back('{{32'd3, 32'd0}, 1'b0});
        @(posedge clk);
        #1;
        Signal = OPO;
        repeat (5) @(negedge clk);
        Signal = DIVU;
        dataA  = 32'd9;
        dataB  = 32'd3;
        repeat (3) @(negedge clk);
        Signal = OPO;
        dc = done_cnt;
        repeat (40) @(negedge clk);
        chk("busy_ignore_dones", 64'(done_cnt - dc), 64'd1);

        // back-to-back: DIVU presented in the DONE cycle
        do_div(32'd1000, 32'd10, '{{32'd0, 32'd100}, 1'b0});
        do_div(32'd81, 32'd9, '{{32'd0, 32'd9}, 1'b0});
        @(negedge clk);

        // reset mid-divide aborts without a done pulse
        Signal = DIVU;
        dataA  = 32'd1000;
        dataB  = 32'd10;
        @(posedge clk);
        #1;
        Signal = OPO;
        repeat (10) @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        chk("abort_dataOut", dataOut, 64'd0);
        chk("abort_flags", {61'd0, busy, done, div_by_zero}, 64'd0);
        reset = 1'b0;
        dc = done_cnt;
        repeat (40) @(negedge clk);
        chk("abort_no_done", 64'(done_cnt - dc), 64'd0);

        for (int i = 0; i < 1000; i++) begin
            a = $urandom;
            b = (i % 4 == 0) ? 32'($urandom_range(1, 255)) : $urandom;
            if (b == 0) b = 32'd1;
            do_div(a, b, model(a, b));
            qq = dataOut[W-1:0];
            rr = dataOut[2*W-1:W];
            chk("invariant", 64'(qq) * 64'(b) + 64'(rr), 64'(a));
            chk("rem_lt_div", {63'd0, rr < b}, 64'd1);
        end

        @(negedge clk);
        chk("sb_empty", 64'(sb.size()), 64'd0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
